// File: rtl/min_reduce_arbiter_if.sv
// min_reduce_arbiter_if: request bus between the SAD cores and the min-reduce arbiter
interface min_reduce_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int VAL_W   = 13,
    parameter int TAG_W   = 32
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*VAL_W-1:0] req_value;
    logic [NUM_REQ*TAG_W-1:0] req_tag;
    logic [NUM_REQ-1:0]       req_ready;
    modport master (output req_valid, req_value, req_tag, input req_ready);
    modport slave  (input req_valid, req_value, req_tag, output req_ready);
endinterface

// File: rtl/min_reduce_arbiter.sv
// min_reduce_arbiter: round-robin grant of core SAD results folded into a running minimum with tag
module min_reduce_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int VAL_W   = 13,
    parameter int TAG_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     total_count,
    min_reduce_arbiter_if.slave  req,
    output logic                 busy,
    output logic                 done,
    output logic [VAL_W-1:0]     min_value,
    output logic [TAG_W-1:0]     min_tag,
    output logic                 min_found,
    output logic [CNT_W-1:0]     accepted
);
    localparam int RR_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, CLEAR, COLLECT, DONE} state_t;
    state_t           state, state_nxt;
    logic [RR_W-1:0]  rr, sel, idx, rr_nxt;
    logic             hit, xfer, clr;
    logic [CNT_W-1:0] total_lat;
    logic [VAL_W-1:0] vals [NUM_REQ];
    logic [TAG_W-1:0] tags [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign vals[g] = req.req_value[g*VAL_W +: VAL_W];
        assign tags[g] = req.req_tag[g*TAG_W +: TAG_W];
    end
    // Cyclic search from rr; walking offsets high to low lets the nearest valid core win
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = RR_W'((int'(rr) + k) % NUM_REQ);
            if (req.req_valid[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end
    assign xfer   = (state == COLLECT) && hit;
    assign rr_nxt = (sel == RR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    assign clr    = (state == CLEAR) || (state == IDLE && start && total_count == '0);
    // State register
    always_ff @(posedge Clk) state <= Rst ? IDLE : state_nxt;
    // Next state, one-hot grant and status flags
    always_comb begin
        state_nxt     = state;
        req.req_ready = '0;
        req.req_ready[sel] = xfer;
        busy = (state == CLEAR) || (state == COLLECT);
        done = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = (total_count == '0) ? DONE : CLEAR;
            CLEAR:   state_nxt = COLLECT;
            COLLECT: if (xfer && accepted + 1'b1 == total_lat) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    // Min register, tag, result count, total latch and round-robin pointer
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr        <= '0;
            total_lat <= '0;
            min_value <= '1;
            min_tag   <= '1;
            min_found <= 1'b0;
            accepted  <= '0;
        end else begin
            if (state == IDLE && start) total_lat <= total_count;
            if (clr) begin
                min_value <= '1;
                min_tag   <= '1;
                min_found <= 1'b0;
                accepted  <= '0;
            end else if (xfer) begin
                accepted <= accepted + 1'b1;
                rr       <= rr_nxt;
                if (vals[sel] < min_value) begin
                    min_value <= vals[sel];
                    min_tag   <= tags[sel];
                    min_found <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_min_reduce_arbiter.sv
// tb_min_reduce_arbiter: randomized and directed checks of min_reduce_arbiter against a behavioural model
module tb_min_reduce_arbiter;
    localparam int NR = 4, VW = 13, TW = 32, CW = 16;
    localparam int P_IDLE = 0, P_CLEAR = 1, P_COLLECT = 2, P_DONE = 3;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [CW-1:0] total_count = '0;
    logic busy, done, min_found;
    logic [VW-1:0] min_value;
    logic [TW-1:0] min_tag;
    logic [CW-1:0] accepted;
    min_reduce_arbiter_if #(.NUM_REQ(NR), .VAL_W(VW), .TAG_W(TW)) bus ();
    min_reduce_arbiter #(.NUM_REQ(NR), .VAL_W(VW), .TAG_W(TW), .CNT_W(CW)) dut (
        .Clk(clk), .Rst(rst), .start(start), .total_count(total_count), .req(bus),
        .busy(busy), .done(done), .min_value(min_value), .min_tag(min_tag),
        .min_found(min_found), .accepted(accepted)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask
    // Behavioural model: what the outputs must be in the current cycle
    int m_phase = P_IDLE, m_rr = 0, m_total = 0, m_acc = 0;
    logic [VW-1:0] m_min = '1;
    logic [TW-1:0] m_tag = '1;
    bit m_found = 1'b0;
    logic [NR-1:0] xfer_mask = '0;
    int gnt_log[$];
    always @(negedge clk) begin : compare
        int g;
        logic [NR-1:0] er;
        logic [VW-1:0] v;
        logic [TW-1:0] t;
        g = -1;
        er = '0;
        if (m_phase == P_COLLECT)
            for (int k = 0; k < NR; k++)
                if (g < 0 && bus.req_valid[(m_rr + k) % NR]) g = (m_rr + k) % NR;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", bus.req_ready, er);
        chk("busy", busy, m_phase == P_CLEAR || m_phase == P_COLLECT);
        chk("done", done, m_phase == P_DONE);
        chk("min_value", min_value, m_min);
        chk("min_tag", min_tag, m_tag);
        chk("min_found", min_found, m_found);
        chk("accepted", accepted, m_acc);
        xfer_mask = bus.req_ready & bus.req_valid;
        for (int k = 0; k < NR; k++) if (xfer_mask[k]) gnt_log.push_back(k);
        if (rst) begin
            m_phase = P_IDLE; m_rr = 0; m_acc = 0; m_min = '1; m_tag = '1; m_found = 1'b0;
        end else if (m_phase == P_IDLE) begin
            if (start) begin
                m_total = int'(total_count);
                if (m_total == 0) begin
                    m_phase = P_DONE; m_min = '1; m_tag = '1; m_found = 1'b0; m_acc = 0;
                end else m_phase = P_CLEAR;
            end
        end else if (m_phase == P_CLEAR) begin
            m_phase = P_COLLECT; m_min = '1; m_tag = '1; m_found = 1'b0; m_acc = 0;
        end else if (m_phase == P_COLLECT) begin
            if (g >= 0) begin
                v = bus.req_value[g*VW +: VW];
                t = bus.req_tag[g*TW +: TW];
                m_acc++;
                if (v < m_min) begin
                    m_min = v; m_tag = t; m_found = 1'b1;
                end
                m_rr = (g + 1) % NR;
                if (m_acc == m_total) m_phase = P_DONE;
            end
        end else m_phase = P_IDLE;
    end
    // Requester side: per-core queues, each head held valid until granted
    logic [VW-1:0] qv[NR][$];
    logic [TW-1:0] qt[NR][$];
    int gap[NR];
    bit rand_gaps = 1'b0;
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (xfer_mask[i] && qv[i].size() > 0) begin
                void'(qv[i].pop_front());
                void'(qt[i].pop_front());
                bus.req_valid[i] = 1'b0;
                gap[i] = rand_gaps ? int'($urandom_range(0, 2)) : 0;
            end
            if (!bus.req_valid[i] && qv[i].size() > 0) begin
                if (gap[i] == 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_value[i*VW +: VW] = qv[i][0];
                    bus.req_tag[i*TW +: TW] = qt[i][0];
                end else gap[i]--;
            end
        end
    endtask
    task automatic flush();
        for (int i = 0; i < NR; i++) begin
            qv[i].delete();
            qt[i].delete();
            bus.req_valid[i] = 1'b0;
            gap[i] = 0;
        end
    endtask
    task automatic load(input int c, input logic [VW-1:0] v, input logic [TW-1:0] t);
        qv[c].push_back(v);
        qt[c].push_back(t);
    endtask
    task automatic wait_done(input string nm, input int lim);
        int n;
        n = 0;
        while (done !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done got %b expected 1 within %0d cycles", nm, done, lim);
        end
    endtask
    task automatic search(input string nm, input int total, input int lim);
        start = 1'b1;
        total_count = CW'(total);
        tick();
        start = 1'b0;
        wait_done(nm, lim);
    endtask
    task automatic check_log(input string nm, input int exp[$]);
        chk({nm, "_len"}, gnt_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < gnt_log.size(); i++) chk(nm, gnt_log[i], exp[i]);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int e[$];
        int n, total, extra, c;
        logic [VW-1:0] v;
        bus.req_valid = '0;
        bus.req_value = '0;
        bus.req_tag = '0;
        flush();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_min_value", min_value, 13'h1FFF);
        chk("rst_min_tag", min_tag, 32'hFFFF_FFFF);
        chk("rst_min_found", min_found, 0);
        chk("rst_accepted", accepted, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", bus.req_ready, 0);
        gnt_log.delete();
        load(0, 100, 'hA); load(1, 50, 'hB); load(2, 50, 'hC); load(3, 200, 'hD);
        tick();
        search("t1", 4, 50);
        chk("t1_min_value", min_value, 50);
        chk("t1_min_tag", min_tag, 'hB);
        chk("t1_min_found", min_found, 1);
        chk("t1_accepted", accepted, 4);
        e = '{0, 1, 2, 3};
        check_log("t1_order", e);
        tick();
        flush();
        gnt_log.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) load(i, VW'(300 + 10*r + i), TW'(32'h100 + 16*r + i));
        tick();
        search("t2", 8, 50);
        chk("t2_accepted", accepted, 8);
        chk("t2_min_value", min_value, 300);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_log("t2_order", e);
        tick();
        flush();
        load(0, 60, 'h60); load(1, 61, 'h61);
        tick();
        search("t3_setup", 2, 50);
        tick();
        flush();
        gnt_log.delete();
        load(1, 20, 'h21); load(3, 30, 'h31); load(3, 10, 'h32);
        tick();
        search("t3", 3, 50);
        e = '{3, 1, 3};
        check_log("t3_order", e);
        chk("t3_model_rr", m_rr, 0);
        chk("t3_min_value", min_value, 10);
        chk("t3_min_tag", min_tag, 'h32);
        tick();
        flush();
        start = 1'b1;
        total_count = '0;
        tick();
        start = 1'b0;
        chk("t4_done_next_cycle", done, 1);
        chk("t4_min_value", min_value, 13'h1FFF);
        chk("t4_min_tag", min_tag, 32'hFFFF_FFFF);
        chk("t4_min_found", min_found, 0);
        chk("t4_accepted", accepted, 0);
        tick();
        chk("t4_done_pulse", done, 0);
        load(1, 13'h1FFF, 'h1234);
        tick();
        search("t4_ones", 1, 50);
        chk("t4_ones_found", min_found, 0);
        chk("t4_ones_tag", min_tag, 32'hFFFF_FFFF);
        chk("t4_ones_accepted", accepted, 1);
        tick();
        flush();
        gnt_log.delete();
        for (int j = 0; j < 5; j++) load(0, VW'(40 + j), TW'(32'h50 + j));
        tick();
        start = 1'b1;
        total_count = 5;
        tick();
        start = 1'b0;
        n = 0;
        while (gnt_log.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_two_grants", gnt_log.size(), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush();
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_min_value", min_value, 13'h1FFF);
        chk("t5_min_tag", min_tag, 32'hFFFF_FFFF);
        chk("t5_accepted", accepted, 0);
        chk("t5_ready", bus.req_ready, 0);
        repeat (3) begin
            tick();
            chk("t5_no_done", done, 0);
        end
        load(2, 7, 'h77);
        tick();
        search("t5_restart", 1, 50);
        chk("t5_min_value7", min_value, 7);
        chk("t5_min_found", min_found, 1);
        chk("t5_min_tag77", min_tag, 'h77);
        tick();
        flush();
        load(0, 9, 'h90);
        tick();
        start = 1'b1;
        total_count = 3;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        total_count = 1;
        tick();
        start = 1'b0;
        load(1, 5, 'h51); load(2, 5, 'h52);
        wait_done("t6", 50);
        chk("t6_accepted", accepted, 3);
        chk("t6_min_value", min_value, 5);
        chk("t6_min_tag", min_tag, 'h51);
        tick();
        flush();
        rand_gaps = 1'b1;
        repeat (60) begin
            total = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            extra = int'($urandom_range(0, 3));
            for (int j = 0; j < total + extra; j++) begin
                c = int'($urandom_range(0, NR - 1));
                v = ($urandom_range(0, 4) == 0) ? 13'h1FFF : VW'($urandom_range(0, 60));
                load(c, v, TW'($urandom));
            end
            tick();
            search("rand", total, 400);
            tick();
            flush();
            tick();
        end
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/min_reduce_arbiter.md
# min_reduce_arbiter

Shares one min/tag tracking register among `NUM_REQ` SAD-producing cores. It grants at most one result per cycle in round-robin order, folds each accepted result into a running minimum with its 32-bit position tag, and counts results against a programmed total. It reports completion with a one-cycle `done` pulse. It sits between the per-core SAD pipelines and the result writeback path, and owns clear and search sequencing for the min register.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesting cores (≥2)
- `VAL_W`, 13, SAD value width
- `TAG_W`, 32, tag width
- `CNT_W`, 16, result counter width

Ports:
- `Clk`  in  1  single clock, rising edge
- `Rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a new search; sampled only in IDLE
- `total_count`  in  CNT_W  number of results expected; sampled with `start`
- `req_valid`  in  NUM_REQ  per-core result valid
- `req_value`  in  NUM_REQ*VAL_W  packed values; core i at `[i*VAL_W +: VAL_W]`
- `req_tag`  in  NUM_REQ*TAG_W  packed tags; core i at `[i*TAG_W +: TAG_W]`
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`
- `busy`  out  1  high in CLEAR and COLLECT
- `done`  out  1  one-cycle pulse when the search completes
- `min_value`  out  VAL_W  current minimum
- `min_tag`  out  TAG_W  tag of current minimum
- `min_found`  out  1  at least one accepted result replaced the cleared value
- `accepted`  out  CNT_W  results accepted in the current search

## Operation
- States: IDLE, CLEAR, COLLECT, DONE.
- IDLE
  - `start`=1 with `total_count`≠0 → CLEAR. Latch `total_count`.
  - `start`=1 with `total_count`=0 → DONE. Stored value and tag are set to all-ones, `min_found`=0, `accepted`=0.
  - `start` is ignored in every other state.
- CLEAR (1 cycle)
  - stored {tag, value} ← all-ones; `min_found`←0; `accepted`←0.
  - Next state is COLLECT.
- COLLECT
  - Grant is combinational: the lowest index i at or after round-robin pointer `rr`, searching cyclically, with `req_valid[i]`=1.
  - `req_ready` is all-zero outside COLLECT and when no request is valid.
  - On a transfer:
    - `accepted`+1.
    - If `req_value[i]` < stored value (strict, unsigned), then stored ← {tag_i, value_i} and `min_found`←1.
    - `rr` ← (i+1) mod NUM_REQ.
    - If `accepted`+1 = latched total → DONE.
  - With no transfer, `rr` holds.
- DONE (1 cycle)
  - `done`=1; next state is IDLE.
  - `min_value`, `min_tag`, `min_found`, `accepted` hold until the next CLEAR.
- Ties: a strictly-less compare means the earliest-accepted equal value is retained.
- A value equal to all-ones never replaces the cleared register; `min_found` stays 0 in that case.
- `rr` is not reset by `start`. It persists across searches; only `Rst` zeroes it.
- `min_value`/`min_tag` are driven directly from the stored register.

## Timing
- Reset values:
  - state IDLE; `rr`=0.
  - `min_value` all-ones; `min_tag` all-ones.
  - `min_found`=0, `accepted`=0, `done`=0, `busy`=0, `req_ready`=0.
- `Rst` mid-search aborts immediately to the reset values. No `done` is produced.
- `start` at edge n:
  - CLEAR during cycle n+1.
  - COLLECT from cycle n+2; the first grant is possible in n+2.
- Throughput: one result per cycle while any `req_valid` is high.
- A transfer at cycle k updates `min_*`/`accepted` at the edge ending k. If it is the final transfer, `done`=1 in cycle k+1 and IDLE is entered in k+2.
- Minimum search length (`start` to `done`): 3 cycles for total=1; 1 cycle (`done` in n+1) for total=0.
- Requesters must hold `req_valid`, value and tag stable until granted. Ungranted requests are not lost.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.
- The counter does not wrap. Requests beyond the total are never granted because the state leaves COLLECT.

## Test plan
- Reset, then `start` with total=4 and each core presenting once: values 100,50,50,200 with tags 0xA,0xB,0xC,0xD → grants in order 0,1,2,3; `min_value`=50, `min_tag`=0xB (tie keeps first); `done` pulses in the cycle after the 4th grant.
- All four `req_valid` held high with total=8 and `rr`=0 → grant order 0,1,2,3,0,1,2,3; exactly one `req_ready` bit high per cycle; `accepted`=8.
- Only cores 1 and 3 valid with total=3 and `rr`=2 → grants 3,1,3; `rr` ends at 0.
- total=0 → `done` one cycle after `start`; `min_value`=0x1FFF, `min_tag`=0xFFFFFFFF, `min_found`=0. Separately, a single result of 0x1FFF → `min_found`=0 with the tag unchanged.
- `Rst` asserted after 2 of 5 results → all outputs at reset values the next cycle, no `done`. A new `start` with total=1 and value 7 → `min_value`=7, `min_found`=1.
- `start` pulsed during COLLECT → ignored: total is unchanged and the search completes normally.
